// File: rtl/wm_responder.sv
// Watermark responder: scans the input stream for a trigger sequence, then answers each
// digest chunk input with its paired output chunk until the whole signature has matched.
module wm_responder #(
  parameter int unsigned LENGTH_I = 3,
  parameter int unsigned LENGTH_O = 5,
  parameter int unsigned INIT_LEN = 4,
  parameter logic [INIT_LEN*LENGTH_I-1:0] INIT_PATTERN = 12'b101_010_111_001,
  parameter logic [127:0] MD5 = 128'h0123456789abcdef_fedcba9876543210
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [LENGTH_I-1:0] in,
  output logic [LENGTH_O-1:0] out,
  output logic                wm_active,
  output logic                wm_done
);

  localparam int unsigned Width     = LENGTH_I + LENGTH_O;
  localparam int unsigned NumChunks = (128 + Width - 1) / Width;
  localparam int unsigned PadWidth  = NumChunks * Width;
  localparam int unsigned KW        = (INIT_LEN > 1) ? $clog2(INIT_LEN) : 1;
  localparam int unsigned IW        = (NumChunks > 1) ? $clog2(NumChunks) : 1;

  // Digest left-aligned so that bits past bit 0 of the digest read as zero padding.
  localparam logic [PadWidth-1:0] Md5Pad = PadWidth'(MD5) << (PadWidth - 128);

  typedef enum logic [1:0] {StScan, StEmbed, StDone} state_e;

  state_e        state_q;
  logic [KW-1:0] k_q;
  logic [IW-1:0] idx_q;
  logic          active_q;
  logic          done_q;

  // Tables are padded to a power of two so every counter value indexes a defined entry.
  logic [LENGTH_I-1:0] init_sym [2**KW];
  logic [LENGTH_I-1:0] exp_in   [2**IW];
  logic [LENGTH_O-1:0] exp_out  [2**IW];

  for (genvar s = 0; s < 2**KW; s++) begin : g_init
    if (s < INIT_LEN) begin : g_used
      assign init_sym[s] = INIT_PATTERN[(INIT_LEN-1-s)*LENGTH_I +: LENGTH_I];
    end else begin : g_unused
      assign init_sym[s] = '0;
    end
  end

  for (genvar j = 0; j < 2**IW; j++) begin : g_chunk
    if (j < NumChunks) begin : g_used
      assign exp_in[j]  = Md5Pad[PadWidth-1-j*Width -: LENGTH_I];
      assign exp_out[j] = Md5Pad[PadWidth-1-j*Width-LENGTH_I -: LENGTH_O];
    end else begin : g_unused
      assign exp_in[j]  = '0;
      assign exp_out[j] = '0;
    end
  end

  logic [KW-1:0] k_eff;
  logic          scan_hit;
  logic          scan_last;
  logic          restart_hit;
  logic          chunk_hit;

  // DONE evaluates the current symbol as a fresh scan from step 0.
  assign k_eff       = (state_q == StScan) ? k_q : '0;
  assign scan_hit    = (in == init_sym[k_eff]);
  assign scan_last   = (k_eff == KW'(INIT_LEN - 1));
  assign restart_hit = (in == init_sym[0]);
  assign chunk_hit   = (in == exp_in[idx_q]);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= StScan;
      k_q      <= '0;
      idx_q    <= '0;
      active_q <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      active_q <= 1'b0;
      done_q   <= 1'b0;
      case (state_q)
        StEmbed: begin
          if (chunk_hit) begin
            if (idx_q == IW'(NumChunks - 1)) begin
              state_q <= StDone;
              done_q  <= 1'b1;
              idx_q   <= '0;
              k_q     <= '0;
            end else begin
              idx_q    <= idx_q + IW'(1);
              active_q <= 1'b1;
            end
          end else if (restart_hit && INIT_LEN == 1) begin
            state_q  <= StEmbed;
            active_q <= 1'b1;
            idx_q    <= '0;
          end else begin
            state_q <= StScan;
            idx_q   <= '0;
            if (restart_hit) k_q <= KW'(1);
            else             k_q <= '0;
          end
        end
        default: begin
          if (scan_hit) begin
            if (scan_last) begin
              state_q  <= StEmbed;
              active_q <= 1'b1;
              idx_q    <= '0;
              k_q      <= '0;
            end else begin
              state_q <= StScan;
              k_q     <= k_eff + KW'(1);
            end
          end else begin
            // A mismatching symbol may itself begin a new trigger.
            state_q <= StScan;
            idx_q   <= '0;
            if (restart_hit) k_q <= KW'(1);
            else             k_q <= '0;
          end
        end
      endcase
    end
  end

  always_comb begin
    out = '0;
    if (state_q == StEmbed && chunk_hit) out = exp_out[idx_q];
  end

  assign wm_active = active_q;
  assign wm_done   = done_q;

endmodule

// File: tb/tb_wm_responder.sv
// Directed bench for wm_responder: default geometry on one instance, 4/6-bit symbols on another.
module tb_wm_responder;

  localparam logic [127:0] Md5Def = 128'h0123456789abcdef_fedcba9876543210;

  logic       clk;
  logic       reset;
  logic [2:0] din_a;
  logic [4:0] out_a;
  logic       act_a;
  logic       done_a;
  logic [3:0] din_b;
  logic [5:0] out_b;
  logic       act_b;
  logic       done_b;

  int checks;
  int errors;

  logic [7:0] a_chunk [16];
  logic [2:0] trig_a  [4];
  logic [3:0] trig_b  [4];

  wm_responder dut_a (
    .clk       (clk),
    .reset     (reset),
    .in        (din_a),
    .out       (out_a),
    .wm_active (act_a),
    .wm_done   (done_a)
  );

  wm_responder #(
    .LENGTH_I     (4),
    .LENGTH_O     (6),
    .INIT_LEN     (4),
    .INIT_PATTERN (16'h5271)
  ) dut_b (
    .clk       (clk),
    .reset     (reset),
    .in        (din_b),
    .out       (out_b),
    .wm_active (act_b),
    .wm_done   (done_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Inputs change on the falling edge; Mealy output is sampled 1 time unit later.
  task automatic apply_a(input logic [2:0] sym);
    @(negedge clk);
    din_a = sym;
    #1;
  endtask

  task automatic apply_b(input logic [3:0] sym);
    @(negedge clk);
    din_b = sym;
    #1;
  endtask

  task automatic a_trigger(input string tag);
    for (int i = 0; i < 4; i++) begin
      apply_a(trig_a[i]);
      check({tag, "_trig_out"}, 32'(out_a), 32'd0);
      check({tag, "_trig_act"}, 32'(act_a), 32'd0);
    end
  endtask

  task automatic a_chunks(input string tag, input int first);
    for (int j = first; j < 16; j++) begin
      apply_a(a_chunk[j][7:5]);
      check($sformatf("%s_chunk%0d_out", tag, j), 32'(out_a), 32'(a_chunk[j][4:0]));
      check($sformatf("%s_chunk%0d_act", tag, j), 32'(act_a), 32'd1);
      check($sformatf("%s_chunk%0d_done", tag, j), 32'(done_a), 32'd0);
    end
    apply_a(3'd3);
    check({tag, "_done_pulse"}, 32'(done_a), 32'd1);
    check({tag, "_done_act"}, 32'(act_a), 32'd0);
    check({tag, "_done_out"}, 32'(out_a), 32'd0);
    apply_a(3'd3);
    check({tag, "_done_clear"}, 32'(done_a), 32'd0);
  endtask

  // Chunk j of the 10-bit geometry, read MSB-first from the digest with zero fill past bit 0.
  function automatic logic [9:0] chunk_b(input int j);
    logic [127:0] m;
    logic [9:0]   c;
    m = Md5Def;
    for (int t = 0; t < 10; t++) begin
      int p;
      p = j * 10 + t;
      c[9-t] = (p < 128) ? m[127-p] : 1'b0;
    end
    return c;
  endfunction

  initial begin
    checks  = 0;
    errors  = 0;
    a_chunk = '{8'h01, 8'h23, 8'h45, 8'h67, 8'h89, 8'hab, 8'hcd, 8'hef,
                8'hfe, 8'hdc, 8'hba, 8'h98, 8'h76, 8'h54, 8'h32, 8'h10};
    trig_a  = '{3'd5, 3'd2, 3'd7, 3'd1};
    trig_b  = '{4'd5, 4'd2, 4'd7, 4'd1};
    reset   = 1'b0;
    din_a   = 3'd3;
    din_b   = 4'hf;
    #1;
    check("rst_out", 32'(out_a), 32'd0);
    check("rst_act", 32'(act_a), 32'd0);
    check("rst_done", 32'(done_a), 32'd0);
    @(negedge clk);
    reset = 1'b1;

    // Full trigger and signature.
    a_trigger("basic");
    a_chunks("basic", 0);

    // Interrupted trigger restarts from step 1, then a wrong symbol at chunk 3.
    apply_a(3'd5); apply_a(3'd2); apply_a(3'd5); apply_a(3'd2);
    check("restart_mid_act", 32'(act_a), 32'd0);
    apply_a(3'd7); apply_a(3'd1);
    check("restart_trig_out", 32'(out_a), 32'd0);
    check("restart_trig_act", 32'(act_a), 32'd0);
    apply_a(3'd0);
    check("restart_c0_act", 32'(act_a), 32'd1);
    check("restart_c0_out", 32'(out_a), 32'd1);
    apply_a(3'd1);
    check("restart_c1_out", 32'(out_a), 32'd3);
    apply_a(3'd2);
    check("restart_c2_out", 32'(out_a), 32'd5);
    apply_a(3'd6);
    check("wrong_c3_out", 32'(out_a), 32'd0);
    check("wrong_c3_act", 32'(act_a), 32'd1);
    apply_a(3'd4);
    check("wrong_after_act", 32'(act_a), 32'd0);
    check("wrong_after_done", 32'(done_a), 32'd0);
    apply_a(3'd4);
    check("wrong_after2_done", 32'(done_a), 32'd0);

    // Mismatch symbol equal to trigger step 0 arms step 1 immediately.
    a_trigger("rearm");
    apply_a(3'd0);
    apply_a(3'd1);
    apply_a(3'd5);
    check("rearm_mis_out", 32'(out_a), 32'd0);
    apply_a(3'd2);
    check("rearm_scan_act", 32'(act_a), 32'd0);
    apply_a(3'd7); apply_a(3'd1);
    apply_a(3'd0);
    check("rearm_c0_act", 32'(act_a), 32'd1);
    check("rearm_c0_out", 32'(out_a), 32'd1);
    a_chunks("rearm", 1);

    // Asynchronous reset in the middle of chunk 8.
    a_trigger("abort");
    for (int j = 0; j < 9; j++) apply_a(a_chunk[j][7:5]);
    check("abort_c8_out", 32'(out_a), 32'd30);
    check("abort_c8_act", 32'(act_a), 32'd1);
    #2;
    reset = 1'b0;
    #1;
    check("abort_async_out", 32'(out_a), 32'd0);
    check("abort_async_act", 32'(act_a), 32'd0);
    check("abort_async_done", 32'(done_a), 32'd0);
    @(negedge clk);
    check("abort_held_done", 32'(done_a), 32'd0);
    din_a = 3'd5;
    reset = 1'b1;
    apply_a(3'd2); apply_a(3'd7); apply_a(3'd1);
    check("post_rst_trig_act", 32'(act_a), 32'd0);
    apply_a(3'd0);
    check("post_rst_c0_act", 32'(act_a), 32'd1);
    check("post_rst_c0_out", 32'(out_a), 32'd1);
    a_chunks("post_rst", 1);

    // Wider symbols: 13 chunks, last one carries two padding zeros.
    din_a = 3'd3;
    for (int i = 0; i < 4; i++) begin
      apply_b(trig_b[i]);
      check("wide_trig_out", 32'(out_b), 32'd0);
    end
    for (int j = 0; j < 13; j++) begin
      logic [9:0] c;
      c = chunk_b(j);
      apply_b(c[9:6]);
      check($sformatf("wide_chunk%0d_out", j), 32'(out_b), 32'(c[5:0]));
      check($sformatf("wide_chunk%0d_act", j), 32'(act_b), 32'd1);
    end
    check("wide_last_in", 32'(din_b), 32'd1);
    apply_b(4'hf);
    check("wide_done_pulse", 32'(done_b), 32'd1);
    check("wide_done_act", 32'(act_b), 32'd0);
    apply_b(4'hf);
    check("wide_done_clear", 32'(done_b), 32'd0);
    check("a_idle_done", 32'(done_a), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
